// File: rtl/project_button_pkg.sv
// Shared constants for the project_button Avalon-MM input PIO.
package project_button_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int DB_CNT_W = 16;

endpackage

// File: rtl/project_button_debounce.sv
// One input bit: two-flop synchronizer, plus a stability counter filter when
// PROJECT_BUTTON_DEBOUNCE_EN is defined.
module project_button_debounce
  import project_button_pkg::*;
`ifdef PROJECT_BUTTON_DEBOUNCE_EN
  #(parameter int DEBOUNCE_CYCLES = 16)
`endif
  (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic filt,
  output logic filt_next
);

  logic sync1, sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= in_bit;
      sync2 <= sync1;
    end
  end

`ifdef PROJECT_BUTTON_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] cnt, cnt_next;

  // The filtered bit follows sync2 only after it has disagreed for DEBOUNCE_CYCLES clocks
  always_comb begin
    cnt_next  = '0;
    filt_next = filt;
    if (sync2 != filt) begin
      if (cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_next = sync2;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      filt <= filt_next;
    end
  end
`else
  assign filt      = sync2;
  assign filt_next = sync1;
`endif

endmodule

// File: rtl/project_button.sv
// Avalon-MM push-button input PIO with sticky edge capture and maskable irq.
// Optional input debouncing is enabled by defining PROJECT_BUTTON_DEBOUNCE_EN.
module project_button
  import project_button_pkg::*;
  #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] filt, filt_next, prev, edge_det, irq_mask, edge_cap, clr;
  logic [31:0]      rd_mux;
  logic             arm_stage, armed, wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
`ifdef PROJECT_BUTTON_DEBOUNCE_EN
    project_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
`else
    project_button_debounce u_db (
`endif
      .clk       (clk),
      .reset     (reset),
      .in_bit    (in_port[i]),
      .filt      (filt[i]),
      .filt_next (filt_next[i])
    );
  end

`ifndef PROJECT_BUTTON_DEBOUNCE_EN
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
`endif

  always_comb begin
    case (EDGE_TYPE)
      EDGE_RISE: edge_det = filt & ~prev;
      EDGE_FALL: edge_det = ~filt & prev;
      default:   edge_det = filt ^ prev;
    endcase
  end

  assign wr_en = chipselect & ~write_n;
  assign clr   = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = filt;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edge_cap;
      default:      rd_mux = '0;
    endcase
  end

  // Until armed, prev tracks the value filt is about to take, so a level that
  // was already present at reset release never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_stage <= 1'b0;
      armed     <= 1'b0;
      prev      <= '0;
      irq_mask  <= '0;
      edge_cap  <= '0;
      readdata  <= '0;
    end else begin
      arm_stage <= 1'b1;
      armed     <= arm_stage;
      prev      <= armed ? filt : filt_next;
      if (wr_en && address == ADDR_IRQMASK) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      edge_cap  <= (edge_cap & ~clr) | (armed ? edge_det : '0);
      readdata  <= rd_mux;
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_project_button.sv
// Self-checking bench for project_button (WIDTH=4, falling-edge capture).
// Define PROJECT_BUTTON_DEBOUNCE_EN to also exercise the debounce filter.
module tb_project_button;
  import project_button_pkg::*;

  localparam int WIDTH = 4;
  localparam int TB_DC = 8;
`ifdef PROJECT_BUTTON_DEBOUNCE_EN
  localparam int LAT = 3 + TB_DC;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  int n_cmp = 0;
  int n_bad = 0;

  project_button #(.WIDTH(WIDTH), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(TB_DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Reference model: filtered value is the pin value seen one edge earlier
  // (or a run-length debounced version of it); falling edges are recognised
  // only between two filtered values that both come from post-reset samples.
  logic [WIDTH-1:0] m_in1, m_in2, m_filt, m_filt_old, m_mask, m_cap, m_newcap, m_nf;
  logic [31:0]      m_rd;
  int               m_edges;
  int               m_run [WIDTH];
  logic             m_irq;

  assign m_irq = |(m_cap & m_mask);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_in1 = '0; m_in2 = '0; m_filt = '0; m_filt_old = '0;
      m_mask = '0; m_cap = '0; m_rd = '0; m_edges = 0;
      for (int b = 0; b < WIDTH; b++) m_run[b] = 0;
    end else begin
      case (address)
        ADDR_DATA:    m_rd = {28'd0, m_filt};
        ADDR_IRQMASK: m_rd = {28'd0, m_mask};
        ADDR_EDGECAP: m_rd = {28'd0, m_cap};
        default:      m_rd = 32'd0;
      endcase
      m_newcap = m_cap;
      if (chipselect && !write_n && address == ADDR_EDGECAP)
        m_newcap = m_newcap & ~writedata[WIDTH-1:0];
      if (m_edges + 1 >= 4)
        m_newcap = m_newcap | (m_filt_old & ~m_filt);
      if (chipselect && !write_n && address == ADDR_IRQMASK)
        m_mask = writedata[WIDTH-1:0];
`ifdef PROJECT_BUTTON_DEBOUNCE_EN
      m_nf = m_filt;
      for (int b = 0; b < WIDTH; b++) begin
        if (m_in2[b] != m_filt[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == TB_DC) begin
            m_nf[b]  = m_in2[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
`else
      m_nf = m_in1;
`endif
      m_filt_old = m_filt;
      m_filt     = m_nf;
      m_in2      = m_in1;
      m_in1      = in_port;
      m_cap      = m_newcap;
      if (m_edges < 1000) m_edges = m_edges + 1;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      n_cmp++;
      if (readdata !== m_rd || irq !== m_irq) begin
        n_bad++;
        $display("[TB] FAIL cycle_compare at %0t: readdata=%h irq=%b, model readdata=%h irq=%b",
                 $time, readdata, irq, m_rd, m_irq);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] a, input logic wr, input logic [31:0] d);
    address    = a;
    chipselect = wr;
    write_n    = ~wr;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; in_port = 4'hF; address = ADDR_DATA;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_irq", {31'd0, irq}, 32'h0);
    reset = 1'b0;

    $display("[TB] arming with inputs held high");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0);
      checkOutput("arm_edgecap", readdata, 32'h0);
      checkOutput("arm_irq", {31'd0, irq}, 32'h0);
    end
    applyStimulus(ADDR_DATA, 1'b0, 32'h0);
    checkOutput("arm_data", readdata, 32'hF);

    $display("[TB] falling capture on bit1");
    applyStimulus(ADDR_IRQMASK, 1'b1, 32'h3);
    address = ADDR_EDGECAP;
    in_port = 4'hD;
    for (int i = 1; i <= LAT + 1; i++) begin
      @(negedge clk);
      if (i < LAT) checkOutput("fall_irq_early", {31'd0, irq}, 32'h0);
      else if (i == LAT) checkOutput("fall_irq_rise", {31'd0, irq}, 32'h1);
    end
    checkOutput("fall_edgecap", readdata, 32'h2);
    applyStimulus(ADDR_EDGECAP, 1'b1, 32'h2);
    checkOutput("fall_clear_irq", {31'd0, irq}, 32'h0);

    $display("[TB] masked capture on bit0");
    applyStimulus(ADDR_IRQMASK, 1'b1, 32'h0);
    in_port = 4'hC;
    repeat (LAT + 1) @(negedge clk);
    applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0);
    checkOutput("mask_edgecap", readdata, 32'h1);
    checkOutput("mask_irq_off", {31'd0, irq}, 32'h0);
    applyStimulus(ADDR_IRQMASK, 1'b1, 32'h1);
    checkOutput("mask_irq_on", {31'd0, irq}, 32'h1);

    $display("[TB] set/clear collision on bit0");
    in_port = 4'hD;
    repeat (LAT + 2) @(negedge clk);
    in_port = 4'hC;
    repeat (LAT - 1) @(negedge clk);
    applyStimulus(ADDR_EDGECAP, 1'b1, 32'h1);
    applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0);
    checkOutput("collide_edgecap", readdata, 32'h1);
    checkOutput("collide_irq", {31'd0, irq}, 32'h1);
    applyStimulus(ADDR_EDGECAP, 1'b1, 32'h1);
    applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0);
    checkOutput("clear_edgecap", readdata, 32'h0);
    checkOutput("clear_irq", {31'd0, irq}, 32'h0);

    $display("[TB] register map");
    applyStimulus(ADDR_RSVD, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(ADDR_DATA, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(ADDR_RSVD, 1'b0, 32'h0);
    checkOutput("rsvd_read", readdata, 32'h0);
    applyStimulus(ADDR_IRQMASK, 1'b0, 32'h0);
    checkOutput("map_mask_kept", readdata, 32'h1);
    applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0);
    checkOutput("map_edgecap_kept", readdata, 32'h0);
    applyStimulus(ADDR_DATA, 1'b0, 32'h0);
    checkOutput("map_data", readdata, 32'hC);
    applyStimulus(ADDR_IRQMASK, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(ADDR_IRQMASK, 1'b0, 32'h0);
    checkOutput("mask_width", readdata, 32'hF);

    $display("[TB] reset during pending interrupt");
    in_port = 4'h8;
    repeat (LAT + 1) @(negedge clk);
    checkOutput("pending_irq", {31'd0, irq}, 32'h1);
    #2 reset = 1'b1;
    #1 checkOutput("async_reset_irq", {31'd0, irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(ADDR_IRQMASK, 1'b0, 32'h0);
    checkOutput("reset_mask_lost", readdata, 32'h0);
    applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0);
    checkOutput("reset_edgecap_lost", readdata, 32'h0);

`ifdef PROJECT_BUTTON_DEBOUNCE_EN
    $display("[TB] debounce glitch and stable edge");
    repeat (LAT + 4) @(negedge clk);
    applyStimulus(ADDR_IRQMASK, 1'b1, 32'hF);
    in_port = 4'h0;
    repeat (5) @(negedge clk);
    in_port = 4'h8;
    repeat (LAT + 4) @(negedge clk);
    applyStimulus(ADDR_DATA, 1'b0, 32'h0);
    checkOutput("glitch_data", readdata, 32'h8);
    applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0);
    checkOutput("glitch_edgecap", readdata, 32'h0);
    in_port = 4'h0;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clk);
      if (i < LAT) checkOutput("db_irq_early", {31'd0, irq}, 32'h0);
      else checkOutput("db_irq_rise", {31'd0, irq}, 32'h1);
    end
    repeat (6) @(negedge clk);
    in_port = 4'h8;
    repeat (LAT + 4) @(negedge clk);
    applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0);
    checkOutput("db_edgecap", readdata, 32'h8);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
